// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes and FSM state encoding
// for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        STAT,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Brings SCK/CS_n/MOSI into the aclk domain and
// produces 1-cycle edge pulses aligned with the data.
module spi_in_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sck,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_n,
    output logic o_cs_fall,
    output logic o_cs_rise,
    output logic o_mosi
);

    logic [1:0] r_sck_s;
    logic [1:0] r_cs_s;
    logic [1:0] r_mosi_s;
    logic       r_sck_h;
    logic       r_cs_h;
    logic       r_mosi;
    logic       r_sck_rise;
    logic       r_sck_fall;
    logic       r_cs_fall;
    logic       r_cs_rise;

    // Two-stage sync, then history stage and registered edge pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sck_s    <= '0;
            r_cs_s     <= '0;
            r_mosi_s   <= '0;
            r_sck_h    <= 1'b0;
            r_cs_h     <= 1'b0;
            r_mosi     <= 1'b0;
            r_sck_rise <= 1'b0;
            r_sck_fall <= 1'b0;
            r_cs_fall  <= 1'b0;
            r_cs_rise  <= 1'b0;
        end else begin
            r_sck_s    <= {r_sck_s[0], i_sck};
            r_cs_s     <= {r_cs_s[0], i_cs_n};
            r_mosi_s   <= {r_mosi_s[0], i_mosi};
            r_sck_h    <= r_sck_s[1];
            r_cs_h     <= r_cs_s[1];
            r_mosi     <= r_mosi_s[1];
            r_sck_rise <= r_sck_s[1] & ~r_sck_h;
            r_sck_fall <= ~r_sck_s[1] & r_sck_h;
            r_cs_fall  <= ~r_cs_s[1] & r_cs_h;
            r_cs_rise  <= r_cs_s[1] & ~r_cs_h;
        end
    end

    assign o_sck_rise = r_sck_rise;
    assign o_sck_fall = r_sck_fall;
    assign o_cs_n     = r_cs_h;
    assign o_cs_fall  = r_cs_fall;
    assign o_cs_rise  = r_cs_rise;
    assign o_mosi     = r_mosi;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target: READ/RDID/RDSR decode,
// byte streaming from a memory port with 1-byte prefetch.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W     = 24,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic [7:0]        last_cmd,
    output logic              err_underrun
);

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_n;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_mosi;

    spi_in_sync u_sync (
        .i_clk      (aclk),
        .i_rst      (areset),
        .i_sck      (spi_sck),
        .i_cs_n     (spi_cs_n),
        .i_mosi     (spi_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_cs_n     (w_cs_n),
        .o_cs_fall  (w_cs_fall),
        .o_cs_rise  (w_cs_rise),
        .o_mosi     (w_mosi)
    );

    state_t            r_state;
    logic [4:0]        r_bit_cnt;
    logic [22:0]       r_rx;
    logic [7:0]        r_tx;
    logic              r_miso;
    logic              r_miso_oe;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_want_addr;
    logic              r_want;
    logic              r_pend;
    logic              r_drop;
    logic [7:0]        r_pf_data;
    logic              r_pf_valid;
    logic [1:0]        r_id_idx;
    logic [7:0]        r_last_cmd;
    logic              r_err;

    logic [23:0]       w_rx_next;
    logic [ADDR_W-1:0] w_addr;
    logic              w_cs_hi;
    logic              w_rv_ok;
    logic              w_pf_hit;
    logic [7:0]        w_pf_byte;
    logic              w_free;
    logic              w_load;
    logic [7:0]        w_id_byte;
    logic [7:0]        w_src_byte;

    assign w_rx_next = {r_rx, w_mosi};
    assign w_addr    = w_rx_next[ADDR_W-1:0];
    assign w_cs_hi   = w_cs_n | w_cs_rise;
    // Data landing in the same cycle as the load still counts as in time.
    assign w_rv_ok   = mem_rvalid & r_pend & ~r_drop;
    assign w_pf_hit  = r_pf_valid | w_rv_ok;
    assign w_pf_byte = r_pf_valid ? r_pf_data : mem_rdata;
    assign w_free    = ~r_pend | mem_rvalid;
    assign w_load    = w_sck_fall & (r_bit_cnt == 5'd7);

    // Select the byte to be loaded into the tx shifter.
    always_comb begin
        w_id_byte = 8'h00;
        case (r_id_idx)
            2'd0:    w_id_byte = JEDEC_ID[23:16];
            2'd1:    w_id_byte = JEDEC_ID[15:8];
            2'd2:    w_id_byte = JEDEC_ID[7:0];
            default: w_id_byte = 8'h00;
        endcase
        w_src_byte = STATUS_VAL;
        if (r_state == DATA) begin
            w_src_byte = w_pf_hit ? w_pf_byte : 8'hFF;
        end else if (r_state == ID) begin
            w_src_byte = w_id_byte;
        end
    end

    // Command FSM, shifters, prefetch buffer and memory requests.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_next_addr <= '0;
            r_want_addr <= '0;
            r_want      <= 1'b0;
            r_pend      <= 1'b0;
            r_drop      <= 1'b0;
            r_pf_data   <= '0;
            r_pf_valid  <= 1'b0;
            r_id_idx    <= '0;
            r_last_cmd  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_mem_req <= 1'b0;
            if (mem_rvalid && r_pend) begin
                r_pend <= 1'b0;
                r_drop <= 1'b0;
                if (!r_drop) begin
                    r_pf_data  <= mem_rdata;
                    r_pf_valid <= 1'b1;
                end
            end
            if (r_want && !r_pend && !w_cs_hi) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= r_want_addr;
                r_pend     <= 1'b1;
                r_want     <= 1'b0;
            end
            if (w_cs_hi) begin
                r_state    <= IDLE;
                r_miso     <= 1'b0;
                r_miso_oe  <= 1'b0;
                r_pf_valid <= 1'b0;
                r_want     <= 1'b0;
                if (r_pend && !mem_rvalid) r_drop <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= CMD;
                            r_bit_cnt <= 5'd7;
                        end
                    end
                    CMD: begin
                        if (w_sck_rise) begin
                            r_rx      <= w_rx_next[22:0];
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                            if (r_bit_cnt == 5'd0) begin
                                r_last_cmd <= w_rx_next[7:0];
                                r_id_idx   <= '0;
                                r_bit_cnt  <= 5'd7;
                                case (w_rx_next[7:0])
                                    CMD_READ: begin
                                        r_state   <= ADDR;
                                        r_bit_cnt <= 5'd23;
                                    end
                                    CMD_RDID: r_state <= ID;
                                    CMD_RDSR: r_state <= STAT;
                                    default:  r_state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (w_sck_rise) begin
                            r_rx      <= w_rx_next[22:0];
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                            if (r_bit_cnt == 5'd0) begin
                                r_mem_req   <= 1'b1;
                                r_mem_addr  <= w_addr;
                                r_pend      <= 1'b1;
                                r_drop      <= 1'b0;
                                r_next_addr <= w_addr + ADDR_W'(1);
                                r_bit_cnt   <= 5'd7;
                                r_state     <= DATA;
                            end
                        end
                    end
                    DATA, ID, STAT: begin
                        if (w_sck_fall) begin
                            r_miso_oe <= 1'b1;
                            r_bit_cnt <= (r_bit_cnt == 5'd0) ?
                                         5'd7 : r_bit_cnt - 5'd1;
                            if (w_load) begin
                                r_miso <= w_src_byte[7];
                                r_tx   <= {w_src_byte[6:0], 1'b0};
                            end else begin
                                r_miso <= r_tx[7];
                                r_tx   <= {r_tx[6:0], 1'b0};
                            end
                        end
                        if (w_load && r_state == ID && r_id_idx != 2'd3) begin
                            r_id_idx <= r_id_idx + 2'd1;
                        end
                        if (w_load && r_state == DATA) begin
                            r_pf_valid  <= 1'b0;
                            r_next_addr <= r_next_addr + ADDR_W'(1);
                            if (!w_pf_hit) begin
                                r_err <= 1'b1;
                                if (r_pend && !mem_rvalid) r_drop <= 1'b1;
                            end
                            if (w_free) begin
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= r_next_addr;
                                r_pend     <= 1'b1;
                            end else begin
                                r_want      <= 1'b1;
                                r_want_addr <= r_next_addr;
                            end
                        end
                    end
                    IGNORE: r_miso_oe <= 1'b0;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign spi_miso     = r_miso;
    assign spi_miso_oe  = r_miso_oe;
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign last_cmd     = r_last_cmd;
    assign err_underrun = r_err;

endmodule
